// File: rtl/parity_frame_ctrl_if.sv
// Handshake bundle between a serial bit source and the parity frame controller.
interface parity_frame_ctrl_if #(
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic             abort;
    logic             bit_valid;
    logic             bit_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic             parity_odd;
    logic [CNT_W-1:0] ones_count;
    logic             parity_err;

    modport master (
        output start, abort, bit_valid, bit_in,
        input  ready, busy, done, parity_odd, ones_count, parity_err
    );

    modport slave (
        input  start, abort, bit_valid, bit_in,
        output ready, busy, done, parity_odd, ones_count, parity_err
    );
endinterface

// File: rtl/parity_frame_ctrl.sv
// Frames a serial bit stream into FRAME_LEN data bits plus one parity bit and
// reports ones count, data parity and parity error with a one-cycle done pulse.
module parity_frame_ctrl #(
    parameter int unsigned FRAME_LEN   = 8,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned PARITY_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    parity_frame_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
    localparam logic             MODE_ODD = (PARITY_MODE != 0);

    typedef enum logic [2:0] {
        IDLE,
        RX_PAR,
        RX_IMPAR,
        CHK_PAR,
        CHK_IMPAR,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] ones_cnt;
    logic             clr_cnt;
    logic             inc_bit;
    logic             inc_one;
    logic             load_res;
    logic             odd_after;
    logic             odd_flag;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        clr_cnt    = 1'b0;
        inc_bit    = 1'b0;
        inc_one    = 1'b0;
        load_res   = 1'b0;
        odd_after  = (state == RX_IMPAR) ^ bus.bit_in;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RX_PAR;
                    clr_cnt    = 1'b1;
                end
            end
            RX_PAR, RX_IMPAR: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (bus.bit_valid) begin
                    inc_bit = 1'b1;
                    inc_one = bus.bit_in;
                    if (bit_cnt == LAST_BIT) state_next = odd_after ? CHK_IMPAR : CHK_PAR;
                    else                     state_next = odd_after ? RX_IMPAR  : RX_PAR;
                end
            end
            CHK_PAR, CHK_IMPAR: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (bus.bit_valid) begin
                    state_next = DONE;
                    load_res   = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign odd_flag = (state == CHK_IMPAR);

    // Working counters
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
        end else begin
            if (inc_bit) bit_cnt  <= bit_cnt + CNT_W'(1);
            if (inc_one) ones_cnt <= ones_cnt + CNT_W'(1);
        end
    end

    // Frame results, held until the next completed frame
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.parity_odd <= 1'b0;
            bus.ones_count <= '0;
            bus.parity_err <= 1'b0;
        end else if (load_res) begin
            bus.parity_odd <= odd_flag;
            bus.ones_count <= ones_cnt;
            bus.parity_err <= (bus.bit_in != (odd_flag ^ MODE_ODD));
        end
    end

    // Status flags registered from the next state so they track the state register exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.ready <= (state_next == IDLE);
            bus.busy  <= (state_next inside {RX_PAR, RX_IMPAR, CHK_PAR, CHK_IMPAR});
            bus.done  <= (state_next == DONE);
        end
    end

endmodule

// File: doc/parity_frame_ctrl.md
Name: parity_frame_ctrl

Overview:
- Moore-style controller that sequences a serial bit stream into fixed-length frames and tracks even/odd parity of the data bits.
- Counts the ones in each frame, then checks a trailing parity bit and reports the results with a one-cycle done pulse.
- Sits between a serial receiver (bit_valid/bit_in) and downstream logic that consumes per-frame parity status.

Parameters:
- FRAME_LEN, 8, number of data bits per frame; must be >= 1.
- CNT_W, 4, width of the bit and ones counters; must satisfy 2^CNT_W > FRAME_LEN.
- PARITY_MODE, 0, 0 = even parity (data plus parity bit holds an even number of ones); 1 = odd parity.

Ports:
- clk  input  1  clock; all logic updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a frame; accepted only in IDLE.
- abort  input  1  cancel the frame in progress.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data or parity bit.
- ready  output  1  high in IDLE.
- busy  output  1  high in RX_PAR, RX_IMPAR, CHK_PAR, CHK_IMPAR.
- done  output  1  high for exactly one cycle, in the DONE state.
- parity_odd  output  1  result: data bits of the last completed frame had an odd number of ones.
- ones_count  output  CNT_W  result: number of ones in the data bits of the last completed frame.
- parity_err  output  1  result: received parity bit did not match the expected value.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - State goes to IDLE.
  - Bit counter and ones counter clear to 0.
  - parity_odd, ones_count and parity_err clear to 0.
  - Reset overrides every other input, including mid-frame; no done pulse follows.
- Outputs are Moore, decoded from state only: ready = IDLE, busy = RX_*/CHK_*, done = DONE.
- IDLE:
  - start = 1 -> RX_PAR, clearing the working bit counter and ones counter.
  - bit_valid is ignored, including in the same cycle as start.
- RX_PAR (even so far) / RX_IMPAR (odd so far), on bit_valid = 1:
  - Bit counter increments by 1.
  - bit_in = 1 increments the ones counter and toggles between PAR and IMPAR.
  - bit_in = 0 leaves the parity state unchanged.
  - If this is data bit number FRAME_LEN (bit counter == FRAME_LEN-1 before increment), the next state is CHK_PAR or CHK_IMPAR, matching the parity after this bit.
  - bit_valid = 0: hold state; gaps of any length are allowed.
- CHK_PAR / CHK_IMPAR, on bit_valid = 1:
  - bit_in is the parity bit.
  - Expected parity bit = odd_flag XOR PARITY_MODE, where odd_flag = 1 in CHK_IMPAR.
  - Next state is DONE.
  - Result registers load on this edge: parity_odd = odd_flag, ones_count = working ones count, parity_err = (bit_in != expected).
- DONE: lasts one cycle, then IDLE unconditionally. start is ignored during DONE.
- Latency: done asserts in the cycle after the edge that accepts the parity bit.
- Result registers hold their values until the next completed frame or rst; start does not clear them.
- abort = 1 in RX_* or CHK_*:
  - Next state is IDLE; no done pulse.
  - Result registers are unchanged; working counters are don't-care and are cleared on the next start.
  - abort in IDLE or DONE has no effect.
  - If abort and bit_valid arrive together, abort wins.
- start while busy or in DONE is ignored.
- Counters never wrap within a frame because CNT_W is sized so that 2^CNT_W > FRAME_LEN.

Test Plan:
- rst, start, then data 1,0,1,1,0,0,1,0 (4 ones) with parity bit 0, PARITY_MODE=0, bit_valid every cycle -> done pulses exactly one cycle after the parity bit; parity_odd=0, ones_count=4, parity_err=0; ready returns the following cycle.
- Data 1,1,1,0,0,0,0,0 with parity bit 0 -> ones_count=3, parity_odd=1, parity_err=1; repeat with parity bit 1 -> parity_err=0.
- Same frame as scenario 1 with bit_valid deasserted for 1–5 random cycles between bits -> identical results; done timing is relative to the last valid bit only.
- After a good frame (ones_count=4), start a new frame, send 3 bits, then pulse abort -> IDLE with no done pulse, outputs still 4/0/0; a following full frame completes normally.
- start pulsed during RX_* -> ignored, frame still completes after 8 data bits plus the parity bit; rst asserted mid-frame -> state IDLE, all outputs 0, no done pulse.
- PARITY_MODE=1 instance: all-zero data with parity bit 1 -> parity_err=0; all-ones data (ones_count=8) with parity bit 0 -> parity_err=1, parity_odd=0.
